// File: rtl/exec_muldiv.sv
// exec_muldiv: multi-cycle RV32M execute unit (mul/mulh/mulhsu/mulhu,
// div/divu/rem/remu) sitting beside the single-cycle ALU.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           request valid, accepted only in IDLE when flush=0
//   funct3          RV32M operation select
//   src_a, src_b    forwarded rs1/rs2 operands
//   rd_in           destination register of the request
//   flush           abort an in-flight operation
//   stall           combinational freeze request to the hazard unit
//   done            one-cycle result-valid pulse
//   result, rd_out  result and its destination, held until the next result
//
// Optional build macro EXEC_MULDIV_EARLY_OUT_EN: divisions whose divisor is
// zero or whose dividend magnitude is below the divisor magnitude skip the
// iteration phase (3-cycle latency). Undefined: fixed XLEN+1 DIV clocks.
module exec_muldiv #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned RD_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  localparam int unsigned CNT_W = $clog2(XLEN + MUL_STAGES + 1);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d, quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [RD_W-1:0]   rd_q, rd_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Accept-time operand magnitudes and result signs for division
  logic            sdiv_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  assign sdiv_c  = ~funct3[0];
  assign mag_a_c = (sdiv_c && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b_c = (sdiv_c && src_b[XLEN-1]) ? -src_b : src_b;

  // Full-width product; operands sign-extended only where the op is signed
  logic signed [XLEN:0] ea_c, eb_c;
  logic [PW-1:0]        prod_c, mul_out_c;
  assign ea_c   = {((op_q == 2'd1) || (op_q == 2'd2)) & a_q[XLEN-1], a_q};
  assign eb_c   = {(op_q == 2'd1) & b_q[XLEN-1], b_q};
  assign prod_c = PW'(ea_c) * PW'(eb_c);

  // MUL_STAGES-1 free-running registers after the multiplier; the last
  // stage is the result register loaded on the edge entering DONE.
  if (MUL_STAGES > 1) begin : g_pipe
    logic [PW-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q[0] <= prod_c;
        for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_out_c = pipe_q[MUL_STAGES-2];
  end else begin : g_nopipe
    assign mul_out_c = prod_c;
  end

  // One restoring step: shift next dividend bit into the partial remainder
  logic [XLEN:0] rem_sh_c;
  logic          ge_c;
  assign rem_sh_c = {rem_q, quo_q[XLEN-1]};
  assign ge_c     = rem_sh_c >= {1'b0, dvsr_q};

  // Sign fix; divide-by-zero overrides with all-ones / dividend
  logic [XLEN-1:0] q_fix_c, r_fix_c;
  always_comb begin
    q_fix_c = qneg_q ? -quo_q : quo_q;
    r_fix_c = rneg_q ? -rem_q : rem_q;
    if (dvsr_q == '0) begin
      q_fix_c = '1;
      r_fix_c = a_q;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = funct3[1:0];
          a_d     = src_a;
          b_d     = src_b;
          rd_d    = rd_in;
          cnt_d   = '0;
          dvsr_d  = mag_b_c;
          quo_d   = mag_a_c;
          rem_d   = '0;
          qneg_d  = sdiv_c & (src_a[XLEN-1] ^ src_b[XLEN-1]);
          rneg_d  = sdiv_c & src_a[XLEN-1];
          state_d = funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
          result_d = (op_q == 2'd0) ? mul_out_c[XLEN-1:0] : mul_out_c[PW-1:XLEN];
          rd_out_d = rd_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(XLEN)) begin
          result_d = op_q[1] ? r_fix_c : q_fix_c;
          rd_out_d = rd_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
        end else if ((cnt_q == '0) && ((dvsr_q == '0) || (quo_q < dvsr_q))) begin
          // Quotient is 0 (or overridden); remainder is the whole dividend
          rem_d = quo_q;
          quo_d = '0;
          cnt_d = CNT_W'(XLEN);
`endif
        end else begin
          rem_d = ge_c ? XLEN'(rem_sh_c - {1'b0, dvsr_q}) : rem_sh_c[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge_c};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign stall  = ((state_q == S_IDLE) && start && !flush) ||
                  (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Bench for exec_muldiv (XLEN=32, MUL_STAGES=2). Directed vectors with
// hand-computed results; a driver pushes expectations into a scoreboard
// and a negedge monitor checks every done pulse against it.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  exec_muldiv #(.XLEN(32), .MUL_STAGES(2), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .flush(flush),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

`ifdef EXEC_MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  localparam int MUL_LAT = 3;   // MUL_STAGES+1
  localparam int DIV_LAT = 34;  // XLEN+2

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   extra_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        extra_done++;
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result=%h rd=%0d with no op outstanding", result, rd_out);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        // cycle 1 is the one beginning at the accepting edge
        check("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
    end
  end

  function automatic int div_lat(input bit eo_ok);
    return (eo_ok && EO) ? 3 : DIV_LAT;
  endfunction

  // Issue one op, wait for its done, and check stall over the whole op.
  // poke drives a stray start mid-operation, which must be ignored.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input bit poke);
    int stalls;
    bit seen;
    @(negedge clk);
    funct3 = f3; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    sb.push_back('{res: res, rd: rd, lat: lat});
    #1 check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    stalls = 1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 1) begin
        funct3 = 3'd0; src_a = 32'd1; src_b = 32'd1; rd_in = 5'd31; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall) stalls++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done for funct3=%0d a=%h b=%h", f3, a, b);
    end else begin
      check("stall_cycles", 32'(stalls), 32'(lat));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    src_a = '0; src_b = '0; rd_in = '0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // multiplies
    issue(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT, 1'b0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, MUL_LAT, 1'b0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, MUL_LAT, 1'b0);
    issue(3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, MUL_LAT, 1'b0);
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, MUL_LAT, 1'b0);
    // divides
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, div_lat(0), 1'b0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, div_lat(0), 1'b0);
    issue(3'd5, 32'd100,      32'd7,        5'd12, 32'd14,       div_lat(0), 1'b1);
    issue(3'd7, 32'd100,      32'd7,        5'd13, 32'd2,        div_lat(0), 1'b0);
    // divide by zero and signed overflow
    issue(3'd5, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, div_lat(1), 1'b0);
    issue(3'd6, 32'd5,        32'd0,        5'd15, 32'd5,        div_lat(1), 1'b0);
    issue(3'd4, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF, div_lat(1), 1'b0);
    issue(3'd6, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB, div_lat(1), 1'b0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, div_lat(0), 1'b0);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, div_lat(0), 1'b0);
    // small dividend (early-out candidate)
    issue(3'd5, 32'd3,        32'd10,       5'd20, 32'd0,        div_lat(1), 1'b0);
    issue(3'd7, 32'd3,        32'd10,       5'd21, 32'd3,        div_lat(1), 1'b0);

    // flush mid-div: no done, outputs keep the remu 3%10 result
    @(negedge clk);
    funct3 = 3'd4; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd22; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_result", result, 32'd3);
    check("flush_rd", 32'(rd_out), 32'd21);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(extra_done), 32'd0);
    issue(3'd0, 32'd6, 32'd7, 5'd23, 32'd42, MUL_LAT, 1'b0);

    // asynchronous reset between edges in the middle of a divide
    @(negedge clk);
    funct3 = 3'd4; src_a = 32'hFFFFFFF9; src_b = 32'd2; rd_in = 5'd24; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd", 32'(rd_out), 32'd0);
    @(negedge clk);
    funct3 = 3'd0; src_a = 32'd3; src_b = 32'd3; rd_in = 5'd25; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_result", result, 32'd0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd26, 32'hFFFFFFFE, MUL_LAT, 1'b0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        5'd27, 32'hFFFFFFFD, div_lat(0), 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("no_extra_done", 32'(extra_done), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
